// File: rtl/fc_frame_tx.sv
// Two-slot ping-pong frame buffer that replays each binarized feature frame to fc_layer
// as POS_NUM beats of CH_NUM parallel bits, followed by a forced idle gap.
module fc_frame_tx #(
    parameter int unsigned CH_NUM     = 16,
    parameter int unsigned POS_NUM    = 25,
    parameter int unsigned GAP_CYCLES = 1,
    localparam int unsigned FRAME_BITS = CH_NUM * POS_NUM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FRAME_BITS-1:0] in_frame,
    output logic                  valid_out,
    output logic [CH_NUM-1:0]     pixel_out,
    output logic                  frame_done,
    output logic                  busy,
    output logic [15:0]           frames_sent
);

    localparam int unsigned BEAT_W = (POS_NUM > 1) ? $clog2(POS_NUM) : 1;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned IDX_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(POS_NUM - 1);
    localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] slot_q [2];
    logic [FRAME_BITS-1:0] rd_slot;
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            occ_q, occ_d;
    logic [BEAT_W-1:0]     beat_q, beat_d, sel_beat;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic [CH_NUM-1:0]     pix_q, pix_d, sel_pix;
    logic [15:0]           sent_q;
    logic                  capture, release_slot;

    assign in_ready = (occ_q != 2'd2);
    assign capture  = in_valid && in_ready;
    assign rd_slot  = slot_q[rd_ptr_q];

    // Beat to present on the next edge: beat 0 when leaving IDLE, else the successor.
    assign sel_beat = (state_q == StSend) ? beat_q + 1'b1 : '0;

    always_comb begin
        logic [IDX_W-1:0] idx;
        sel_pix = '0;
        idx     = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            idx        = IDX_W'(c * POS_NUM) + IDX_W'(sel_beat);
            sel_pix[c] = rd_slot[idx];
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        gap_d        = gap_q;
        valid_d      = 1'b0;
        done_d       = 1'b0;
        pix_d        = pix_q;
        release_slot = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (occ_q != 2'd0) begin
                    state_d = StSend;
                    beat_d  = '0;
                    valid_d = 1'b1;
                    pix_d   = sel_pix;
                    done_d  = (POS_NUM == 1);
                end
            end
            StSend: begin
                if (beat_q == LAST_BEAT) begin
                    release_slot = 1'b1;
                    state_d      = StGap;
                    gap_d        = '0;
                end else begin
                    beat_d  = sel_beat;
                    valid_d = 1'b1;
                    pix_d   = sel_pix;
                    done_d  = (sel_beat == LAST_BEAT);
                end
            end
            StGap: begin
                if (gap_q == LAST_GAP) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        if (capture && !release_slot) begin
            occ_d = occ_q + 2'd1;
        end else if (!capture && release_slot) begin
            occ_d = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            occ_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            beat_q   <= '0;
            gap_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            pix_q    <= '0;
            sent_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            pix_q   <= pix_d;
            if (capture) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (release_slot) begin
                rd_ptr_q <= ~rd_ptr_q;
                sent_q   <= sent_q + 16'd1;
            end
        end
    end

    // Slot storage needs no reset; occupancy alone says which slots hold live frames.
    always_ff @(posedge clk) begin
        if (capture) begin
            slot_q[wr_ptr_q] <= in_frame;
        end
    end

    assign valid_out   = valid_q;
    assign pixel_out   = pix_q;
    assign frame_done  = done_q;
    assign busy        = (occ_q != 2'd0) || (state_q != StIdle);
    assign frames_sent = sent_q;

endmodule
